// File: rtl/ddr_frame_reader_256.sv
// Avalon-MM read master: fetches 256-bit beats one read at a time and
// streams each beat out as eight 32-bit words, LSB word first.
module ddr_frame_reader_256 #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = 25
) (
   input  logic              avalon_clk,
   input  logic              avalon_reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       beat_count,
   output logic              busy,
   output logic              done,
   output logic              rd_error,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [ADDR_W-1:0] amm_addr,
   output logic              amm_read,
   output logic [31:0]       amm_byteenable,
   output logic [6:0]        amm_burstcount,
   input  logic [255:0]      amm_readdata,
   input  logic              amm_readdatavalid,
   input  logic              amm_ready
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_STREAM,
      S_DONE
   } state_t;

   state_t            state, nxt;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       remaining;
   logic [2:0]        idx;
   logic [TW-1:0]     tcnt;
   logic [7:0][31:0]  hold;

   logic handshake, last_word, tout_hit;

   assign handshake = (state == S_STREAM) && out_ready;
   assign last_word = (idx == 3'd7);
   assign tout_hit  = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge avalon_clk or posedge avalon_reset) begin
      if (avalon_reset) state <= S_IDLE;
      else              state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (start) nxt = (beat_count == 16'd0) ? S_DONE : S_REQ;
         S_REQ:    if (amm_ready) nxt = S_WAIT;
         S_WAIT: begin
            if (amm_readdatavalid) nxt = S_STREAM;
            else if (tout_hit)     nxt = S_DONE;
         end
         S_STREAM: if (handshake && last_word) nxt = (remaining == 16'd1) ? S_DONE : S_REQ;
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge avalon_clk or posedge avalon_reset) begin
      if (avalon_reset) begin
         addr      <= '0;
         remaining <= '0;
         idx       <= '0;
         tcnt      <= '0;
         hold      <= '0;
         rd_error  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               rd_error  <= 1'b0;
               addr      <= base_addr;
               remaining <= beat_count;
            end
            S_REQ: if (amm_ready) tcnt <= '0;
            S_WAIT: begin
               if (amm_readdatavalid) begin
                  hold <= amm_readdata;
                  idx  <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (tout_hit) rd_error <= 1'b1;
               end
            end
            S_STREAM: if (handshake) begin
               // idx wraps 7->0 on its own; the beat bookkeeping moves on the last word
               idx <= idx + 3'd1;
               if (last_word) begin
                  remaining <= remaining - 16'd1;
                  addr      <= addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign out_valid      = (state == S_STREAM);
   assign out_last       = out_valid && last_word && (remaining == 16'd1);
   assign out_data       = hold[idx];
   assign amm_read       = (state == S_REQ);
   assign amm_addr       = addr;
   assign amm_byteenable = '1;
   assign amm_burstcount = 7'd1;

endmodule

// File: tb/tb_ddr_frame_reader_256.sv
// Directed bench for ddr_frame_reader_256: Avalon slave and stream sink run in
// the background, each scenario task drives a transfer and checks the result.
module tb_ddr_frame_reader_256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start, busy, done, rd_error;
   logic [24:0]  base_addr, amm_addr;
   logic [15:0]  beat_count;
   logic [31:0]  out_data, amm_byteenable;
   logic         out_valid, out_ready, out_last, amm_read;
   logic [6:0]   amm_burstcount;
   logic [255:0] amm_readdata;
   logic         amm_readdatavalid, amm_ready;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // slave controls (written by tests) and status (written by slave)
   int lat = 3;
   bit no_rsp = 0;
   int stall_goal = 0;
   int force_req = 0;
   int stalls_done = 0;
   int acc_cyc = 0;
   logic [24:0] acc_q[$];

   // sink/monitor status
   bit rdy_mode = 0;
   logic [31:0] w_q[$];
   bit l_q[$];
   int c_q[$];
   int stall_err = 0, vld_seen = 0, req_cyc = 0, addr_chg = 0;

   ddr_frame_reader_256 #(.TIMEOUT_CYCLES(16), .ADDR_W(25)) dut (
      .avalon_clk(clk), .avalon_reset(rst), .start(start), .base_addr(base_addr),
      .beat_count(beat_count), .busy(busy), .done(done), .rd_error(rd_error),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .amm_addr(amm_addr), .amm_read(amm_read), .amm_byteenable(amm_byteenable),
      .amm_burstcount(amm_burstcount), .amm_readdata(amm_readdata),
      .amm_readdatavalid(amm_readdatavalid), .amm_ready(amm_ready));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] word_of(input logic [24:0] a, input int k);
      if (a == 25'h10) begin
         case (k)
            0: return 32'h00000000;
            1: return 32'h00000040;
            2: return 32'h000014CC;
            3: return 32'h2005BF6B;
            4: return 32'h1322AABB;
            5: return 32'hFF110800;
            6: return 32'h4500002E;
            default: return 32'h00004000;
         endcase
      end
      return {a[15:0], 13'h1A00, 3'(k)};
   endfunction

   // Avalon slave: decides ready/readdatavalid on the falling edge
   initial begin
      int cd, fack;
      logic [24:0] pend;
      cd = 0; fack = 0; pend = '0;
      amm_ready = 1'b0; amm_readdatavalid = 1'b0; amm_readdata = '0;
      forever begin
         @(negedge clk);
         amm_readdatavalid = 1'b0;
         if (rst) cd = 0;
         else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               amm_readdatavalid = 1'b1;
               for (int k = 0; k < 8; k++) amm_readdata[32*k +: 32] = word_of(pend, k);
            end
         end
         if (force_req != fack) begin
            fack = force_req;
            amm_readdatavalid = 1'b1;
            amm_readdata = {8{32'hDEADBEEF}};
         end
         if (amm_read && stalls_done < stall_goal) begin
            amm_ready = 1'b0;
            stalls_done++;
         end else amm_ready = 1'b1;
         if (amm_read && amm_ready && !rst) begin
            acc_q.push_back(amm_addr);
            acc_cyc = cyc;
            if (!no_rsp) begin cd = lat; pend = amm_addr; end
         end
      end
   end

   // stream sink and bus monitor
   initial begin
      bit prev_stall, prev_read;
      logic [31:0] prev_data;
      logic [24:0] prev_addr;
      prev_stall = 0; prev_read = 0; prev_data = '0; prev_addr = '0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = rdy_mode ? ~out_ready : 1'b1;
         if (prev_stall && !rst && (!out_valid || out_data !== prev_data)) stall_err++;
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (out_valid && out_ready) begin
            w_q.push_back(out_data); l_q.push_back(out_last); c_q.push_back(cyc);
         end
         if (out_valid) vld_seen++;
         if (amm_read) begin
            req_cyc++;
            if (prev_read && amm_addr !== prev_addr) addr_chg++;
         end
         prev_read = amm_read;
         prev_addr = amm_addr;
      end
   end

   task automatic pulse_start(input logic [24:0] b, input logic [15:0] n);
      @(negedge clk); start = 1'b1; base_addr = b; beat_count = n;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         if (done) begin ok = 1; break; end
         @(negedge clk);
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL %s: done not seen within %0d cycles", nm, bound); end
   endtask

   // checks that words w0.. of the sink log match n beats starting at base b
   task automatic check_words(input string nm, input int w0, input logic [24:0] b, input int n);
      logic [24:0] a;
      tests++;
      if (w_q.size() - w0 != 8*n) begin
         fails++; $display("FAIL %s_count: got %0d words, want %0d", nm, w_q.size() - w0, 8*n);
      end else begin
         for (int j = 0; j < 8*n; j++) begin
            a = b + 25'(j/8);
            tests++;
            if (w_q[w0+j] !== word_of(a, j%8)) begin
               fails++; $display("FAIL %s_word%0d: got %h, want %h", nm, j, w_q[w0+j], word_of(a, j%8));
            end
            tests++;
            if (l_q[w0+j] !== (j == 8*n-1)) begin
               fails++; $display("FAIL %s_last%0d: got %0b, want %0b", nm, j, l_q[w0+j], (j == 8*n-1));
            end
         end
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      logic [31:0] got [8];
      got = '{32'(busy), 32'(done), 32'(rd_error), 32'(out_valid), 32'(out_last), out_data, 32'(amm_read), 32'(amm_addr)};
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (got[i] !== 32'h0) begin fails++; $display("FAIL %s_out%0d: got %h, want 0", nm, i, got[i]); end
      end
   endtask

   task automatic test_reset();
      start = 1'b0; base_addr = '0; beat_count = '0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      tests++;
      if (amm_byteenable !== 32'hFFFFFFFF || amm_burstcount !== 7'd1) begin
         fails++; $display("FAIL reset_const: be=%h bc=%0d, want ffffffff/1", amm_byteenable, amm_burstcount);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [31:0] exp [8];
      int w0, a0;
      bit ok;
      exp = '{32'h00000000, 32'h00000040, 32'h000014CC, 32'h2005BF6B,
              32'h1322AABB, 32'hFF110800, 32'h4500002E, 32'h00004000};
      w0 = w_q.size(); a0 = acc_q.size(); rdy_mode = 0; lat = 3;
      pulse_start(25'h10, 16'd1);
      tests++;
      if (busy !== 1'b1 || amm_read !== 1'b1 || amm_addr !== 25'h10) begin
         fails++; $display("FAIL single_req: busy=%0b read=%0b addr=%h, want 1/1/10", busy, amm_read, amm_addr);
      end
      wait_done("single_done", 60, ok);
      tests++;
      if (w_q.size() - w0 != 8) begin
         fails++; $display("FAIL single_count: got %0d words, want 8", w_q.size() - w0);
      end else begin
         for (int k = 0; k < 8; k++) begin
            tests++;
            if (w_q[w0+k] !== exp[k] || l_q[w0+k] !== (k == 7)) begin
               fails++; $display("FAIL single_word%0d: got %h last=%0b, want %h last=%0b", k, w_q[w0+k], l_q[w0+k], exp[k], (k == 7));
            end
         end
         // readdatavalid 3 cycles after acceptance, out_valid 1 cycle later
         tests++;
         if (c_q[w0] != acc_cyc + 4) begin
            fails++; $display("FAIL single_latency: first word at %0d, want %0d", c_q[w0], acc_cyc + 4);
         end
         tests++;
         if (cyc != c_q[w0+7] + 1) begin
            fails++; $display("FAIL single_done_time: done at %0d, want %0d", cyc, c_q[w0+7] + 1);
         end
      end
      tests++;
      if (acc_q.size() - a0 != 1 || acc_q[a0] !== 25'h10) begin
         fails++; $display("FAIL single_reads: got %0d reads, first %h, want 1 at 10", acc_q.size() - a0, acc_q[a0]);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL single_after: done=%0b busy=%0b, want 0/0", done, busy);
      end
   endtask

   task automatic test_backpressure();
      int w0, a0, s0;
      bit ok;
      w0 = w_q.size(); a0 = acc_q.size(); s0 = stall_err; rdy_mode = 1; lat = 2;
      pulse_start(25'h100, 16'd3);
      wait_done("bp_done", 300, ok);
      rdy_mode = 0;
      check_words("bp", w0, 25'h100, 3);
      tests++;
      if (acc_q.size() - a0 != 3) begin
         fails++; $display("FAIL bp_reads: got %0d reads, want 3", acc_q.size() - a0);
      end else for (int i = 0; i < 3; i++) begin
         tests++;
         if (acc_q[a0+i] !== 25'h100 + 25'(i)) begin
            fails++; $display("FAIL bp_addr%0d: got %h, want %h", i, acc_q[a0+i], 25'h100 + 25'(i));
         end
      end
      tests++;
      if (stall_err != s0) begin fails++; $display("FAIL bp_stable: %0d unstable stalls, want 0", stall_err - s0); end
      @(negedge clk);
   endtask

   task automatic test_ready_stall();
      int w0, a0, r0, c0;
      bit ok;
      w0 = w_q.size(); a0 = acc_q.size(); r0 = req_cyc; c0 = addr_chg; lat = 2;
      stall_goal = stalls_done + 20;
      pulse_start(25'h2A0, 16'd1);
      pulse_start(25'h777, 16'd5);   // busy: must be ignored
      wait_done("stall_done", 100, ok);
      repeat (3) @(negedge clk);
      tests++;
      if (req_cyc - r0 != 21) begin fails++; $display("FAIL stall_req_cycles: got %0d, want 21", req_cyc - r0); end
      tests++;
      if (addr_chg != c0) begin fails++; $display("FAIL stall_addr_stable: %0d changes, want 0", addr_chg - c0); end
      tests++;
      if (acc_q.size() - a0 != 1 || acc_q[a0] !== 25'h2A0) begin
         fails++; $display("FAIL stall_reads: got %0d reads, first %h, want 1 at 2a0", acc_q.size() - a0, acc_q[a0]);
      end
      check_words("stall", w0, 25'h2A0, 1);
   endtask

   task automatic test_wrap();
      int w0, a0;
      bit ok;
      w0 = w_q.size(); a0 = acc_q.size(); lat = 1;
      pulse_start(25'h1FFFFFF, 16'd2);
      wait_done("wrap_done", 100, ok);
      tests++;
      if (acc_q.size() - a0 != 2 || acc_q[a0] !== 25'h1FFFFFF || acc_q[a0+1] !== 25'h0) begin
         fails++; $display("FAIL wrap_addr: got %0d reads %h %h, want 1ffffff 0000000", acc_q.size() - a0, acc_q[a0], acc_q[a0+1]);
      end
      check_words("wrap", w0, 25'h1FFFFFF, 2);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int w0, v0;
      bit ok;
      w0 = w_q.size(); no_rsp = 1;
      pulse_start(25'h40, 16'd1);
      wait_done("tout_done", 60, ok);
      tests++;
      if (cyc - (acc_cyc + 1) != 16) begin
         fails++; $display("FAIL tout_time: done %0d cycles after acceptance, want 16", cyc - (acc_cyc + 1));
      end
      tests++;
      if (rd_error !== 1'b1) begin fails++; $display("FAIL tout_flag: rd_error=%0b, want 1", rd_error); end
      tests++;
      if (w_q.size() != w0) begin fails++; $display("FAIL tout_words: got %0d words, want 0", w_q.size() - w0); end
      no_rsp = 0;
      v0 = vld_seen;
      force_req++;
      repeat (5) @(negedge clk);
      tests++;
      if (vld_seen != v0 || busy !== 1'b0) begin
         fails++; $display("FAIL tout_late: valid cycles=%0d busy=%0b, want 0/0", vld_seen - v0, busy);
      end
      tests++;
      if (rd_error !== 1'b1) begin fails++; $display("FAIL tout_sticky: rd_error=%0b, want 1", rd_error); end
      w0 = w_q.size(); lat = 2;
      pulse_start(25'h50, 16'd1);
      tests++;
      if (rd_error !== 1'b0) begin fails++; $display("FAIL tout_clear: rd_error=%0b, want 0", rd_error); end
      wait_done("tout_next_done", 60, ok);
      check_words("tout_next", w0, 25'h50, 1);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int w0, a0, v0, n;
      bit ok;
      w0 = w_q.size(); lat = 2; rdy_mode = 0;
      pulse_start(25'h300, 16'd4);
      n = 0;
      while (w_q.size() - w0 < 10 && n < 200) begin @(negedge clk); n++; end
      tests++;
      if (n >= 200) begin fails++; $display("FAIL rmid_reach: only %0d words, want 10", w_q.size() - w0); end
      tests++;
      if (!out_valid) begin fails++; $display("FAIL rmid_streaming: out_valid=0, want 1"); end
      rst = 1'b1;
      #1;
      check_idle_outputs("rmid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      v0 = vld_seen;
      force_req++;
      repeat (4) @(negedge clk);
      tests++;
      if (vld_seen != v0 || amm_read !== 1'b0) begin
         fails++; $display("FAIL rmid_stray: valid cycles=%0d read=%0b, want 0/0", vld_seen - v0, amm_read);
      end
      w0 = w_q.size(); a0 = acc_q.size();
      pulse_start(25'h10, 16'd1);
      wait_done("rmid_fresh_done", 60, ok);
      tests++;
      if (acc_q.size() - a0 != 1 || acc_q[a0] !== 25'h10) begin
         fails++; $display("FAIL rmid_fresh_read: got %0d reads, first %h, want 1 at 10", acc_q.size() - a0, acc_q[a0]);
      end
      check_words("rmid_fresh", w0, 25'h10, 1);
      @(negedge clk);
   endtask

   task automatic test_zero();
      int r0, a0, v0;
      r0 = req_cyc; a0 = acc_q.size(); v0 = vld_seen;
      pulse_start(25'h123, 16'd0);
      tests++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL zero_done: done=%0b busy=%0b, want 1/1", done, busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL zero_after: done=%0b busy=%0b, want 0/0", done, busy);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (req_cyc != r0 || acc_q.size() != a0 || vld_seen != v0) begin
         fails++; $display("FAIL zero_quiet: req=%0d reads=%0d valid=%0d, want 0/0/0", req_cyc - r0, acc_q.size() - a0, vld_seen - v0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_ready_stall();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_zero();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
